// File: rtl/sw_debounce.sv
// ---------------------------------------------------------------------------
// sw_debounce
//
// Conditions the raw board slide switches before they reach the SoC switch
// input. Each channel goes through a 2-flop synchronizer and a tick-based
// bounce filter. The block then produces a clean level, one-cycle rise/fall
// pulses and a sticky change-pending flag that drives a level interrupt.
//
// Parameters
//   NUM_SW        number of switch channels
//   TICK_DIV      core cycles per sample tick (1 = tick every cycle)
//   STABLE_TICKS  consecutive mismatching ticks needed to accept a new level
//
// Ports
//   clk        core clock
//   rstn       synchronous active-low reset
//   i_sw_raw   asynchronous raw switch pins
//   i_irq_en   per-channel interrupt enable
//   i_clr      write-one-to-clear strobe for pending bits (one cycle)
//   o_sw       debounced switch levels
//   o_rise     one-cycle pulse on an accepted 0->1
//   o_fall     one-cycle pulse on an accepted 1->0
//   o_pending  sticky change flags
//   o_irq      |(o_pending & i_irq_en), combinational
//   o_valid    high once the startup settling window has elapsed
// ---------------------------------------------------------------------------
module sw_debounce #(
  parameter int NUM_SW       = 16,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NUM_SW-1:0] i_sw_raw,
  input  logic [NUM_SW-1:0] i_irq_en,
  input  logic [NUM_SW-1:0] i_clr,
  output logic [NUM_SW-1:0] o_sw,
  output logic [NUM_SW-1:0] o_rise,
  output logic [NUM_SW-1:0] o_fall,
  output logic [NUM_SW-1:0] o_pending,
  output logic              o_irq,
  output logic              o_valid
);

  // TICK_DIV=1 would give a zero-width prescaler; keep one bit that stays 0.
  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW   = $clog2(STABLE_TICKS + 1);
  // Startup counter must hold up to STABLE_TICKS+1.
  localparam int SW_W = $clog2(STABLE_TICKS + 2);

  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0]   CNT_LAST   = CW'(STABLE_TICKS - 1);
  localparam logic [SW_W-1:0] START_LAST = SW_W'(STABLE_TICKS + 1);

  logic [NUM_SW-1:0] sync1_q, sync1_d;
  logic [NUM_SW-1:0] sync2_q, sync2_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [CW-1:0]     cnt_q [NUM_SW];
  logic [CW-1:0]     cnt_d [NUM_SW];
  logic [NUM_SW-1:0] sw_q, sw_d;
  logic [NUM_SW-1:0] rise_q, rise_d;
  logic [NUM_SW-1:0] fall_q, fall_d;
  logic [NUM_SW-1:0] pend_q, pend_d;
  logic [SW_W-1:0]   start_cnt_q, start_cnt_d;
  logic              valid_q, valid_d;
  logic              tick;
  logic [NUM_SW-1:0] accept;

  always_comb begin
    // Synchronizer: only sync2 is used downstream.
    sync1_d = i_sw_raw;
    sync2_d = sync1_q;

    // Prescaler: tick in the cycle where the count sits at TICK_DIV-1.
    tick    = (presc_q == PRESC_LAST);
    presc_d = tick ? '0 : presc_q + PW'(1);

    // Bounce filter. A matching sample clears the counter on every cycle,
    // tick or not, so any return to the accepted level restarts the count.
    // The counter is cleared on acceptance and never reaches STABLE_TICKS.
    sw_d   = sw_q;
    accept = '0;
    for (int i = 0; i < NUM_SW; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == sw_q[i]) begin
        cnt_d[i] = '0;
      end else if (tick) begin
        if (cnt_q[i] == CNT_LAST) begin
          sw_d[i]   = sync2_q[i];
          cnt_d[i]  = '0;
          accept[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end

    // Levels still settle during startup, but edges are hidden so switches
    // already on at power-up never raise an interrupt.
    rise_d = valid_q ? (accept & sync2_q)  : '0;
    fall_d = valid_q ? (accept & ~sync2_q) : '0;

    // A new edge beats a simultaneous clear.
    pend_d = (pend_q & ~i_clr) | rise_d | fall_d;

    // Startup window: o_valid rises on the (STABLE_TICKS+2)-th tick.
    start_cnt_d = start_cnt_q;
    valid_d     = valid_q;
    if (tick && !valid_q) begin
      if (start_cnt_q == START_LAST) begin
        valid_d = 1'b1;
      end else begin
        start_cnt_d = start_cnt_q + SW_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      presc_q     <= '0;
      sw_q        <= '0;
      rise_q      <= '0;
      fall_q      <= '0;
      pend_q      <= '0;
      start_cnt_q <= '0;
      valid_q     <= 1'b0;
      for (int i = 0; i < NUM_SW; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      presc_q     <= presc_d;
      sw_q        <= sw_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      pend_q      <= pend_d;
      start_cnt_q <= start_cnt_d;
      valid_q     <= valid_d;
      for (int i = 0; i < NUM_SW; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign o_sw      = sw_q;
  assign o_rise    = rise_q;
  assign o_fall    = fall_q;
  assign o_pending = pend_q;
  assign o_valid   = valid_q;
  assign o_irq     = |(pend_q & i_irq_en);

endmodule
